// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding and HD44780 power-on command constants
// for the LCD host sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

  localparam int LCD_INIT_LEN = 4;
  localparam int IDX_W        = 2;

  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(LCD_INIT_LEN - 1);

endpackage

// File: rtl/lcd_host_sequencer_if.sv
// lcd_host_sequencer_if: CPU-side request/response handshake
// (master = command logic, slave = sequencer).
interface lcd_host_sequencer_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_rd;
  logic       req_rs;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  modport master (
    output req_valid, req_rd, req_rs, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_rd, req_rs, req_data,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: combinational index-to-command lookup for the
// HD44780 power-on sequence.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       cmd
);

  always_comb begin
    cmd = 8'h00;
    unique case (idx)
      2'd0: cmd = LCD_CMD_FUNCSET;
      2'd1: cmd = LCD_CMD_DISPON;
      2'd2: cmd = LCD_CMD_CLEAR;
      2'd3: cmd = LCD_CMD_ENTRY;
    endcase
  end

endmodule

// File: rtl/lcd_host_sequencer.sv
// lcd_host_sequencer: HD44780 bus initiator; power-on init, then host requests.
// Define LCD_HOST_TIMEOUT_EN to bound every RDY wait and report timeout_err.
module lcd_host_sequencer
  import lcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 12,
  parameter int SETUP_CYCLES   = 1
) (
  input  logic                clk,
  input  logic                rst,
  lcd_host_sequencer_if.slave host,
  output logic                nCS,
  output logic                nWR,
  output logic                nRD,
  output logic                o_rs,
  output logic [7:0]          db_out,
  output logic                db_oe,
  input  logic [7:0]          db_in,
  input  logic                RDY,
  output logic                init_done,
  output logic                timeout_err
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 3 ||
      (1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_cfg_err
    $error("lcd_host_sequencer: bad SETUP_CYCLES or CNT_W");
  end

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] idx;
  logic [7:0]       rom_cmd;
  logic             cyc_rd;
  logic             cyc_rs;
  logic [7:0]       cyc_data;
  logic [1:0]       setup_cnt;
  logic             setup_last;
  logic             tmo_hit;
  logic             to_flag;
  logic             ready;
  logic             rsp_v;
  logic [7:0]       rsp_d;

  lcd_init_rom u_rom (
    .idx (idx),
    .cmd (rom_cmd)
  );

  assign setup_last      = setup_cnt == 2'(SETUP_CYCLES - 1);
  assign o_rs            = cyc_rs;
  assign db_out          = cyc_data;
  assign host.req_ready  = ready;
  assign host.rsp_valid  = rsp_v;
  assign host.rsp_data   = rsp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    nCS     = 1'b1;
    nWR     = 1'b1;
    nRD     = 1'b1;
    db_oe   = 1'b0;
    unique case (state)
      S_INIT:  state_n = S_SETUP;
      S_IDLE: begin
        ready = 1'b1;
        if (host.req_valid) state_n = S_SETUP;
      end
      S_SETUP: begin
        db_oe = !cyc_rd;
        if (setup_last) state_n = S_STROBE;
      end
      S_STROBE: begin
        nCS   = 1'b0;
        nWR   = cyc_rd;
        nRD   = !cyc_rd;
        db_oe = !cyc_rd;
        // stale RDY low on entry counts as the acknowledge
        if (!RDY)         state_n = S_RELEASE;
        else if (tmo_hit) state_n = S_DONE;
      end
      S_RELEASE: begin
        db_oe = !cyc_rd;
        if (RDY || tmo_hit) state_n = S_DONE;
      end
      S_DONE: begin
        if (!init_done && idx != IDX_LAST) state_n = S_INIT;
        else                               state_n = S_IDLE;
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      cyc_rd    <= 1'b0;
      cyc_rs    <= 1'b0;
      cyc_data  <= 8'h00;
      setup_cnt <= 2'd0;
      rsp_v     <= 1'b0;
      rsp_d     <= 8'h00;
      init_done <= 1'b0;
    end else begin
      rsp_v     <= 1'b0;
      setup_cnt <= (state_n != state) ? 2'd0 : setup_cnt + 2'd1;
      if (state == S_INIT) begin
        cyc_rd   <= 1'b0;
        cyc_rs   <= 1'b0;
        cyc_data <= rom_cmd;
      end
      if (state == S_IDLE && host.req_valid) begin
        cyc_rd   <= host.req_rd;
        cyc_rs   <= host.req_rs;
        cyc_data <= host.req_data;
      end
      if (state == S_DONE) begin
        if (cyc_rd && !to_flag) begin
          rsp_v <= 1'b1;
          rsp_d <= db_in;
        end
        if (!init_done) begin
          if (idx == IDX_LAST) init_done <= 1'b1;
          else                 idx       <= idx + IDX_W'(1);
        end
      end
    end
  end

`ifdef LCD_HOST_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt;
  logic             waiting;
  logic             abort;

  assign waiting = state == S_STROBE || state == S_RELEASE;
  assign tmo_hit = waiting && tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign abort   = tmo_hit && ((state == S_STROBE) ? RDY : !RDY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      to_flag     <= 1'b0;
    end else begin
      if (state_n != state) tmo_cnt <= '0;
      else if (waiting)     tmo_cnt <= tmo_cnt + CNT_W'(1);
      // to_flag marks the aborted cycle so DONE emits no response
      if (abort) begin
        timeout_err <= 1'b1;
        to_flag     <= 1'b1;
      end else if (state == S_DONE) begin
        to_flag <= 1'b0;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign to_flag     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_host_sequencer.sv
// tb_lcd_host_sequencer: table-driven requests with a bus/response
// scoreboard against an RDY-handshaking LCD controller model.
module tb_lcd_host_sequencer;

  localparam int T   = 4095;
  localparam int LAT = 12;

  typedef struct {
    bit         rd;
    bit         rs;
    logic [7:0] data;
    logic [7:0] rdv;
    bit         exp_rs;
    logic [7:0] exp_db;
    logic [7:0] exp_rsp;
  } vec_t;

  typedef struct {
    bit         rd;
    bit         rs;
    logic [7:0] db;
  } bus_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       nCS, nWR, nRD, o_rs, db_oe, RDY;
  logic       init_done, timeout_err;
  logic [7:0] db_out, db_in;

  bus_t       bus_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] rdv_q[$];
  vec_t       tbl[10];

  int n_chk = 0;
  int n_fail = 0;
  int viol = 0;
  bit mute = 1'b0;
  int cnt;
  bit rel_chk;
  logic prev_ncs, prev_rs, prev_oe, prev_rsp;
  logic [7:0] prev_db;

  always #5 clk = ~clk;

  lcd_host_sequencer_if host ();

  lcd_host_sequencer #(
    .TIMEOUT_CYCLES (T),
    .CNT_W          (12),
    .SETUP_CYCLES   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (host),
    .nCS         (nCS),
    .nWR         (nWR),
    .nRD         (nRD),
    .o_rs        (o_rs),
    .db_out      (db_out),
    .db_oe       (db_oe),
    .db_in       (db_in),
    .RDY         (RDY),
    .init_done   (init_done),
    .timeout_err (timeout_err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_check();
    bus_t e;
    if (bus_q.size() == 0) begin
      chk("bus_unexpected", 1, 0);
      return;
    end
    e = bus_q.pop_front();
    chk("bus_strobe", {nWR, nRD}, e.rd ? 2'b10 : 2'b01);
    chk("bus_db_oe", db_oe, !e.rd);
    chk("bus_rs", o_rs, e.rs);
    chk("setup_held", {prev_ncs, prev_rs, prev_oe}, {1'b1, e.rs, !e.rd});
    if (!e.rd) begin
      chk("bus_db", db_out, e.db);
      chk("setup_db", prev_db, e.db);
    end else if (rdv_q.size() != 0) begin
      db_in <= rdv_q.pop_front();
    end
  endtask

  task automatic rsp_check();
    if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
    else chk("rsp_data", host.rsp_data, rsp_q.pop_front());
  endtask

  // Controller model: acknowledges a strobe by holding RDY low LAT cycles
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      RDY     <= 1'b1;
      cnt     <= 0;
      rel_chk <= 1'b0;
      db_in   <= 8'h00;
    end else begin
      prev_ncs <= nCS;
      prev_rs  <= o_rs;
      prev_db  <= db_out;
      prev_oe  <= db_oe;
      if (rel_chk) begin
        chk("strobe_release", {nCS, nWR, nRD}, 3'b111);
        rel_chk <= 1'b0;
      end
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) RDY <= 1'b1;
      end else if (!nCS && !mute) begin
        RDY     <= 1'b0;
        cnt     <= LAT;
        rel_chk <= 1'b1;
        bus_check();
      end
    end
  end

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      prev_rsp <= 1'b0;
    end else begin
      prev_rsp <= host.rsp_valid;
      viol <= viol + int'(!nWR && !nRD) + int'((!nWR || !nRD) && nCS)
            + int'(host.req_ready && !init_done)
            + int'(host.req_ready && !RDY)
            + int'(host.rsp_valid && prev_rsp);
      if (host.rsp_valid) rsp_check();
    end
  end

  task automatic push_init();
    logic [7:0] cmds[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    bus_t b;
    for (int i = 0; i < 4; i++) begin
      b.rd = 1'b0;
      b.rs = 1'b0;
      b.db = cmds[i];
      bus_q.push_back(b);
    end
  endtask

  task automatic wait_drain(string tag);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      n++;
      ok = bus_q.size() == 0 && rsp_q.size() == 0 && host.req_ready;
    end
    chk({tag, "_drain"}, ok, 1);
  endtask

  task automatic send(vec_t v, bit keep, bit expect_it);
    int n = 0;
    bus_t b;
    host.req_rd    = v.rd;
    host.req_rs    = v.rs;
    host.req_data  = v.data;
    host.req_valid = 1'b1;
    if (expect_it) begin
      b.rd = v.rd;
      b.rs = v.exp_rs;
      b.db = v.exp_db;
      bus_q.push_back(b);
      if (v.rd) begin
        rsp_q.push_back(v.exp_rsp);
        rdv_q.push_back(v.rdv);
      end
    end
    while (!host.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", host.req_ready, 1);
    @(posedge clk);
    #1;
    chk("req_ready_drop", host.req_ready, 0);
    if (!keep) host.req_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   lo;
    int   k;
    logic pn;
    vec_t tv;

    tbl[0] = '{1'b0, 1'b1, 8'h41, 8'h00, 1'b1, 8'h41, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 8'h80, 1'b0, 8'h00, 8'h80};
    tbl[2] = '{1'b0, 1'b0, 8'h80, 8'h00, 1'b0, 8'h80, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 8'hEE, 8'h5A, 1'b1, 8'h00, 8'h5A};
    tbl[4] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 8'hC3, 1'b0, 8'h00, 8'hC3};
    tbl[7] = '{1'b0, 1'b1, 8'h31, 8'h00, 1'b1, 8'h31, 8'h00};
    tbl[8] = '{1'b1, 1'b1, 8'h00, 8'hA5, 1'b1, 8'h00, 8'hA5};
    tbl[9] = '{1'b0, 1'b0, 8'h7E, 8'h00, 1'b0, 8'h7E, 8'h00};

    rst            = 1'b1;
    host.req_valid = 1'b0;
    host.req_rd    = 1'b0;
    host.req_rs    = 1'b0;
    host.req_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {nCS, nWR, nRD}, 3'b111);
    chk("rst_bus", {o_rs, db_out, db_oe}, 10'h0);
    chk("rst_handshake", {host.req_ready, host.rsp_valid, host.rsp_data}, 10'h0);
    chk("rst_status", {init_done, timeout_err}, 2'b00);
    push_init();
    rst = 1'b0;
    wait_drain("init");
    chk("init_done", init_done, 1);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i], 1'b0, 1'b1);
      wait_drain("req");
    end
    for (int i = 7; i < 10; i++) send(tbl[i], i != 9, 1'b1);
    wait_drain("burst");
    chk("rsp_data_hold", host.rsp_data, 8'hA5);

`ifdef LCD_HOST_TIMEOUT_EN
    mute = 1'b1;
    tv   = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    send(tv, 1'b0, 1'b0);
    n  = 0;
    lo = 0;
    while (!timeout_err && n < T + 200) begin
      @(negedge clk);
      if (!nCS) lo++;
      n++;
    end
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_len", lo, T);
    chk("timeout_strobe_off", {nCS, nWR, nRD}, 3'b111);
    n = 0;
    while (!host.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_idle", host.req_ready, 1);
    repeat (3) @(negedge clk);
    mute = 1'b0;
    send(tbl[0], 1'b0, 1'b1);
    wait_drain("post_timeout");
    chk("timeout_sticky", timeout_err, 1);
`else
    chk("timeout_tied", timeout_err, 0);
`endif

    // Reset during the third init write, then check a clean restart
    rst = 1'b1;
    @(negedge clk);
    bus_q.delete();
    push_init();
    rst = 1'b0;
    n  = 0;
    k  = 0;
    pn = 1'b1;
    while (k < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (!nCS && pn) k++;
      pn = nCS;
    end
    chk("rst_mid_reach", k, 3);
    chk("rst_mid_strobe", {nCS, nWR, db_out}, {1'b0, 1'b0, 8'h01});
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_release", {nCS, nWR, nRD}, 3'b111);
    chk("rst_mid_status", {init_done, host.req_ready, db_oe}, 3'b000);
    @(negedge clk);
    bus_q.delete();
    push_init();
    rst = 1'b0;
    wait_drain("reinit");
    chk("reinit_done", init_done, 1);
    chk("protocol_viol", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
